instr_sequencer: RTL and testbench

Front-end stage of the 10-bit multi-cycle processor: buffers incoming instruction words in a small FIFO, holds the current instruction register, and generates the 2-bit timestep `T` consumed by the combinational controller. It sits directly upstream of the controller, supplying `INSTR` and `T` and reacting to the controller's `IRin` and `Clr` strobes. It stalls the timestep sequence while no instruction is available or while `halt` is high.

---
 rtl/instr_sequencer.sv | 145 ++++++++++++++
 tb/tb_instr_sequencer.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_sequencer.sv
// instr_sequencer: instruction FIFO, instruction register and timestep (T) generator
// for the 10-bit multi-cycle processor front end.
module instr_sequencer #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNTW  = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [9:0]               instr_in,
  input  logic                     instr_valid,
  output logic                     instr_ready,
  input  logic                     halt,
  input  logic                     IRin,
  input  logic                     Clr,
  output logic [9:0]               INSTR,
  output logic [1:0]               T,
  output logic                     busy,
  output logic                     done,
  output logic [$clog2(DEPTH):0]   level,
  output logic [CNTW-1:0]          retired
);

  localparam int unsigned IW = 10;
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned LW = $clog2(DEPTH) + 1;

  typedef enum logic [1:0] {
    FETCH = 2'b00,
    EXEC1 = 2'b01,
    EXEC2 = 2'b10,
    EXEC3 = 2'b11
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [IW-1:0]   r_mem [DEPTH];
  logic [PW-1:0]   r_wptr;
  logic [PW-1:0]   r_rptr;
  logic [LW-1:0]   r_level;
  logic [IW-1:0]   r_instr;
  logic            r_done;
  logic [CNTW-1:0] r_retired;
  logic            w_full;
  logic            w_empty;
  logic            w_push;
  logic            w_load;
  logic            w_retire;

  assign w_full      = (r_level == LW'(DEPTH));
  assign w_empty     = (r_level == '0);
  assign w_push      = instr_valid & ~w_full;
  assign instr_ready = ~w_full;
  assign busy        = (r_state != FETCH);
  assign T           = r_state;
  assign INSTR       = r_instr;
  assign done        = r_done;
  assign level       = r_level;
  assign retired     = r_retired;

  // Next timestep, load and retire decisions; everything freezes while halt is high.
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_retire    = 1'b0;
    if (!halt) begin
      case (r_state)
        FETCH: begin
          if (IRin && !w_empty) begin
            w_load      = 1'b1;
            w_state_nxt = EXEC1;
          end
        end
        EXEC1: begin
          if (Clr) begin
            w_retire    = 1'b1;
            w_state_nxt = FETCH;
          end else begin
            w_state_nxt = EXEC2;
          end
        end
        EXEC2: begin
          if (Clr) begin
            w_retire    = 1'b1;
            w_state_nxt = FETCH;
          end else begin
            w_state_nxt = EXEC3;
          end
        end
        default: begin
          // Last timestep: retires whether or not Clr arrives (missing Clr wraps T).
          w_retire    = 1'b1;
          w_state_nxt = FETCH;
        end
      endcase
    end
  end

  // Timestep state, instruction register, done pulse and retire counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= FETCH;
      r_instr   <= '0;
      r_done    <= 1'b0;
      r_retired <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_done  <= w_retire;
      if (w_load) begin
        r_instr <= r_mem[r_rptr];
      end
      if (w_retire) begin
        r_retired <= r_retired + CNTW'(1);
      end
    end
  end

  // FIFO pointers and occupancy; a load is the only pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + PW'(1);
      end
      if (w_load) begin
        r_rptr <= r_rptr + PW'(1);
      end
      case ({w_push, w_load})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  // FIFO storage; contents need no reset since occupancy gates every read.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= instr_in;
    end
  end

endmodule

// File: tb/tb_instr_sequencer.sv
// Testbench for instr_sequencer: a queue-based reference model predicts every cycle,
// a monitor compares the DUT against the predictions and against the retire order.
`timescale 1ns/1ps
module tb_instr_sequencer;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned CNTW  = 8;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic [9:0]             instr_in;
  logic                   instr_valid;
  logic                   instr_ready;
  logic                   halt;
  logic                   IRin;
  logic                   Clr;
  logic [9:0]             INSTR;
  logic [1:0]             T;
  logic                   busy;
  logic                   done;
  logic [$clog2(DEPTH):0] level;
  logic [CNTW-1:0]        retired;

  instr_sequencer #(.DEPTH(DEPTH), .CNTW(CNTW)) dut (
    .clk(clk), .rst_n(rst_n), .instr_in(instr_in), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .halt(halt), .IRin(IRin), .Clr(Clr),
    .INSTR(INSTR), .T(T), .busy(busy), .done(done), .level(level), .retired(retired)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         t;
    logic [9:0] instr;
    int         lvl;
    int         ready;
    int         bsy;
    int         dn;
    int         ret;
  } snap_t;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state
  logic [9:0] mq[$];
  logic [9:0] ret_q[$];
  snap_t      exp_q[$];
  int         m_t     = 0;
  logic [9:0] m_instr = '0;
  int         m_ret   = 0;
  int         m_total = 0;

  localparam logic [9:0] W_ADD  = 10'b0000010010;
  localparam logic [9:0] W_LOAD = 10'b0001000000;
  localparam logic [9:0] W_COPY = 10'b0010000100;
  localparam logic [9:0] W_INV  = 10'b0011000001;
  localparam logic [9:0] W_ADDI = 10'b0101000110;

  // Controller stand-in: instruction length in timesteps taken from the low two bits
  // (0:LOAD/COPY=2, 1:INV/FLP=3, 2:ALU/imm=4, 3:never clears -> protocol-error wrap).
  function automatic int len_of(input logic [9:0] w);
    case (w[1:0])
      2'd0:    return 2;
      2'd1:    return 3;
      2'd2:    return 4;
      default: return 5;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_T"}, 32'(T), 0);
    chk({tag, "_INSTR"}, 32'(INSTR), 0);
    chk({tag, "_level"}, 32'(level), 0);
    chk({tag, "_ready"}, 32'(instr_ready), 1);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_retired"}, 32'(retired), 0);
  endtask

  task automatic model_reset();
    mq.delete();
    ret_q.delete();
    exp_q.delete();
    m_t     = 0;
    m_instr = '0;
    m_ret   = 0;
  endtask

  // One clock of stimulus; the model predicts the state after the next rising edge.
  task automatic cycle(input bit v, input logic [9:0] d, input bit h, input bit ir,
                       input bit clr_noise);
    bit    clr;
    bit    psh;
    int    dn;
    snap_t s;
    @(negedge clk);
    clr = (m_t != 0) ? (m_t == len_of(m_instr) - 1) : clr_noise;
    instr_valid = v;
    instr_in    = d;
    halt        = h;
    IRin        = ir;
    Clr         = clr;
    psh = v && (mq.size() < DEPTH);
    dn  = 0;
    if (!h) begin
      if (m_t == 0) begin
        if (ir && mq.size() > 0) begin
          m_instr = mq.pop_front();
          m_t     = 1;
        end
      end else if (clr || m_t == 3) begin
        m_t = 0;
        dn  = 1;
        m_ret = (m_ret + 1) % (1 << CNTW);
        m_total++;
        ret_q.push_back(m_instr);
      end else begin
        m_t++;
      end
    end
    if (psh) mq.push_back(d);
    s.t     = m_t;
    s.instr = m_instr;
    s.lvl   = mq.size();
    s.ready = (mq.size() < DEPTH) ? 1 : 0;
    s.bsy   = (m_t != 0) ? 1 : 0;
    s.dn    = dn;
    s.ret   = m_ret;
    exp_q.push_back(s);
  endtask

  // Monitor: compare each post-edge state, and check retire order on every done pulse.
  initial begin
    snap_t      s;
    logic [9:0] w;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        s = exp_q.pop_front();
        chk("T", 32'(T), 32'(s.t));
        chk("INSTR", 32'(INSTR), 32'(s.instr));
        chk("level", 32'(level), 32'(s.lvl));
        chk("instr_ready", 32'(instr_ready), 32'(s.ready));
        chk("busy", 32'(busy), 32'(s.bsy));
        chk("done", 32'(done), 32'(s.dn));
        chk("retired", 32'(retired), 32'(s.ret));
      end
      if (done === 1'b1) begin
        if (ret_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL done_unexpected: got done=1 expected no retirement at %0t", $time);
        end else begin
          w = ret_q.pop_front();
          chk("retire_order", 32'(INSTR), 32'(w));
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int k;
    rst_n = 1'b0; instr_valid = 1'b0; instr_in = '0; halt = 1'b0; IRin = 1'b0; Clr = 1'b0;
    #1;
    chk_reset("reset");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // ADD alone: T 01,10,11,00 then done and retired=1
    cycle(1, W_ADD, 0, 1, 0);
    repeat (6) cycle(0, '0, 0, 1, 0);
    chk("add_retired", 32'(retired), 1);

    // Fill under halt: four accepted, fifth refused; then drain back-to-back
    for (int i = 0; i < 5; i++) cycle(1, 10'(i * 37 + 1), 1, 1, 1);
    chk("full_level", 32'(level), 4);
    chk("full_ready", 32'(instr_ready), 0);
    repeat (20) cycle(0, '0, 0, 1, 0);

    // LOAD, COPY, INV, ADDI stream
    cycle(1, W_LOAD, 0, 1, 0);
    cycle(1, W_COPY, 0, 1, 0);
    cycle(1, W_INV, 0, 1, 0);
    cycle(1, W_ADDI, 0, 1, 0);
    repeat (16) cycle(0, '0, 0, 1, 0);

    // Starved FETCH for 5 cycles, then a push
    repeat (5) cycle(0, '0, 0, 1, 1);
    chk("starve_busy", 32'(busy), 0);
    cycle(1, W_LOAD, 0, 1, 0);
    repeat (4) cycle(0, '0, 0, 1, 0);

    // Randomized traffic including halts, stray strobes and protocol-error words
    for (int i = 0; i < 2000; i++) begin
      cycle($urandom_range(1, 0) == 1, 10'($urandom), $urandom_range(7, 0) == 0,
            $urandom_range(7, 0) != 0, $urandom_range(1, 0) == 1);
    end
    @(posedge clk); #2;
    chk("retired_wrap", 32'(retired), 32'(m_total % (1 << CNTW)));

    // Drain, then reset mid-instruction at T=10 with two words queued
    k = 0;
    while ((mq.size() != 0 || m_t != 0) && k < 200) begin
      cycle(0, '0, 0, 1, 0);
      k++;
    end
    chk("drain_bound", 32'(k < 200), 1);
    for (int i = 0; i < 3; i++) cycle(1, W_ADD, 1, 0, 0);
    cycle(0, '0, 0, 1, 0);
    cycle(0, '0, 0, 0, 0);
    @(posedge clk); #2;
    chk("pre_reset_T", 32'(T), 2);
    chk("pre_reset_level", 32'(level), 2);
    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    #1;
    chk_reset("midreset");
    @(posedge clk); #1;
    chk("midreset_done", 32'(done), 0);
    @(negedge clk);
    rst_n = 1'b1;
    cycle(1, W_INV, 0, 1, 0);
    repeat (6) cycle(0, '0, 0, 1, 0);

    @(posedge clk); #3;
    chk("exp_q_empty", 32'(exp_q.size()), 0);
    chk("ret_q_empty", 32'(ret_q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
